// File: rtl/plic_irq_arbiter_pkg.sv
// Shared constants and types for the single-context PLIC core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package plic_irq_arbiter_pkg;

    localparam int PLIC_NUM_SOURCES = 32;
    localparam int PLIC_PRIO_WIDTH  = 3;
    localparam int PLIC_ID_WIDTH    = $clog2(PLIC_NUM_SOURCES);

    // Static source map; line 0 is reserved and never raises an interrupt.
    localparam int PLIC_GPIO_IN_INTERRUPT = 1;
    localparam int PLIC_TIM0_INTERRUPT    = 2;
    localparam int PLIC_TIM1_INTERRUPT    = 3;
    localparam int PLIC_UART_INTERRUPT    = 4;

    // Hart interrupt line driven by ext_irq_o.
    localparam int CORE_EXT_INTERRUPT = 11;

    // Config register select; encoding 3 is reserved and writes to it are dropped.
    typedef enum logic [1:0] {
        PLIC_CFG_PRIO   = 2'd0,
        PLIC_CFG_EN     = 2'd1,
        PLIC_CFG_THRESH = 2'd2
    } plic_cfg_sel_t;

endpackage

// File: rtl/plic_irq_arbiter_if.sv
// Config-write and claim/complete bus between the hart side (master) and the PLIC (slave).
// Latency: wires only; claim_ack/claim_id are registered inside the PLIC.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//   cfg_we/cfg_sel/cfg_idx/cfg_wdata : single-cycle configuration write
//   claim_req -> claim_ack/claim_id  : claim handshake, ack one cycle after request
//   complete_valid/complete_id       : completion strobe
interface plic_irq_arbiter_if
    import plic_irq_arbiter_pkg::*;
#(
    parameter int ID_WIDTH   = PLIC_ID_WIDTH,
    parameter int PRIO_WIDTH = PLIC_PRIO_WIDTH
);
    logic                  cfg_we;
    logic [1:0]            cfg_sel;
    logic [ID_WIDTH-1:0]   cfg_idx;
    logic [PRIO_WIDTH-1:0] cfg_wdata;

    logic                  claim_req;
    logic                  claim_ack;
    logic [ID_WIDTH-1:0]   claim_id;

    logic                  complete_valid;
    logic [ID_WIDTH-1:0]   complete_id;

    modport master (
        output cfg_we, cfg_sel, cfg_idx, cfg_wdata,
        output claim_req, complete_valid, complete_id,
        input  claim_ack, claim_id
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_idx, cfg_wdata,
        input  claim_req, complete_valid, complete_id,
        output claim_ack, claim_id
    );
endinterface

// File: rtl/plic_irq_arbiter_gateway.sv
// Per-source level gateway: latches a request as pending, tracks it inflight from claim to complete.
// Latency: 1 cycle from irq_i to pending_o; claim/complete take effect at the next edge.
// Backpressure: a source held high is not re-latched while pending or inflight.
//   clock_i, reset_ni       : clock, synchronous active-low reset
//   irq_i                   : level request from the source
//   claim_i / complete_i    : one-cycle strobes already decoded for this source
//   pending_o / inflight_o  : gateway state
module plic_gateway (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic irq_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic inflight_o
);
    logic pending_d,  pending_q;
    logic inflight_d, inflight_q;

    always_comb begin
        // Complete is applied before claim so a same-cycle pair leaves the source inflight.
        inflight_d = inflight_q;
        if (complete_i) inflight_d = 1'b0;
        if (claim_i)    inflight_d = 1'b1;

        // Re-pend uses the registered inflight, so a held source re-pends the cycle after complete.
        pending_d = pending_q;
        if (irq_i && !pending_q && !inflight_q) pending_d = 1'b1;
        if (claim_i)                            pending_d = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            pending_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
        end
    end

    assign pending_o  = pending_q;
    assign inflight_o = inflight_q;
endmodule

// File: rtl/plic_irq_arbiter.sv
// Single-context PLIC core: config registers, gateways, registered max-priority selection, claim/complete.
// Latency: source to ext_irq_o 2 cycles; claim_req to claim_ack 1 cycle; config writes visible to arbitration next cycle.
// Backpressure: none; claims always ack, returning ID 0 when nothing eligible is pending.
//   clock_i, reset_ni : clock, synchronous active-low reset
//   irq_src_i         : level sources, bit 0 ignored
//   bus (slave)       : config writes, claim/ack, complete
//   pending_o         : gateway pending bits for readback
//   ext_irq_o         : hart external interrupt
module plic_irq_arbiter
    import plic_irq_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = PLIC_NUM_SOURCES,
    parameter int PRIO_WIDTH  = PLIC_PRIO_WIDTH,
    parameter int ID_WIDTH    = PLIC_ID_WIDTH
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    plic_irq_arbiter_if.slave      bus,
    output logic [NUM_SOURCES-1:0] pending_o,
    output logic                   ext_irq_o
);
    logic [PRIO_WIDTH-1:0]  prio_d [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0]  prio_q [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] enable_d,    enable_q;
    logic [PRIO_WIDTH-1:0]  thresh_d,    thresh_q;
    logic [ID_WIDTH-1:0]    best_id_d,   best_id_q;
    logic [PRIO_WIDTH-1:0]  best_prio_d, best_prio_q;
    logic                   ext_irq_d,   ext_irq_q;
    logic                   claim_ack_d, claim_ack_q;
    logic [ID_WIDTH-1:0]    claim_id_d,  claim_id_q;

    logic [NUM_SOURCES-1:0] gw_pending;
    logic [NUM_SOURCES-1:0] gw_inflight;
    logic [NUM_SOURCES-1:0] claim_vec;
    logic [NUM_SOURCES-1:0] complete_vec;
    logic                   cfg_idx_ok;
    logic                   complete_ok;
    logic                   claim_hit;
    logic                   sig_unused;

    // ------------------------------------------------------------------
    // Configuration registers. Index 0 is not writable so line 0 can never win.
    // ------------------------------------------------------------------
    assign cfg_idx_ok = (bus.cfg_idx != '0) && (int'(bus.cfg_idx) < NUM_SOURCES);

    always_comb begin
        prio_d   = prio_q;
        enable_d = enable_q;
        thresh_d = thresh_q;
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                PLIC_CFG_PRIO:   if (cfg_idx_ok) prio_d[bus.cfg_idx]   = bus.cfg_wdata;
                PLIC_CFG_EN:     if (cfg_idx_ok) enable_d[bus.cfg_idx] = bus.cfg_wdata[0];
                PLIC_CFG_THRESH: thresh_d = bus.cfg_wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: strict '>' while scanning upwards gives ties to the lowest ID.
    // best_prio starts at 0 and any candidate has prio > threshold >= 0, so
    // the first candidate always replaces the empty result.
    // ------------------------------------------------------------------
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (gw_pending[i] && enable_q[i] && (prio_q[i] > thresh_q) &&
                (prio_q[i] > best_prio_d)) begin
                best_id_d   = ID_WIDTH'(i);
                best_prio_d = prio_q[i];
            end
        end
        // Registered alongside best_id so the source-to-irq path stays at 2 cycles.
        ext_irq_d = (best_id_d != '0);
    end

    // ------------------------------------------------------------------
    // Claim / complete. best_id_q lags pending by a cycle; if that source was
    // claimed last cycle its pending bit is already clear, which masks the
    // stale selection and the claim returns 0.
    // ------------------------------------------------------------------
    assign claim_hit   = bus.claim_req && gw_pending[best_id_q];
    assign claim_vec   = claim_hit ? (NUM_SOURCES'(1) << best_id_q) : '0;
    assign complete_ok = bus.complete_valid && (bus.complete_id != '0) &&
                         (int'(bus.complete_id) < NUM_SOURCES) && gw_inflight[bus.complete_id];
    assign complete_vec = complete_ok ? (NUM_SOURCES'(1) << bus.complete_id) : '0;

    always_comb begin
        claim_ack_d = bus.claim_req;
        claim_id_d  = claim_id_q;
        if (bus.claim_req) claim_id_d = claim_hit ? best_id_q : '0;
    end

    // ------------------------------------------------------------------
    // Gateways for lines 1..NUM_SOURCES-1; line 0 is tied inactive.
    // ------------------------------------------------------------------
    assign gw_pending[0]  = 1'b0;
    assign gw_inflight[0] = 1'b0;

    for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_gw
        plic_gateway u_gw (
            .clock_i    (clock_i),
            .reset_ni   (reset_ni),
            .irq_i      (irq_src_i[i]),
            .claim_i    (claim_vec[i]),
            .complete_i (complete_vec[i]),
            .pending_o  (gw_pending[i]),
            .inflight_o (gw_inflight[i])
        );
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_SOURCES; i++) prio_q[i] <= '0;
            enable_q    <= '0;
            thresh_q    <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            ext_irq_q   <= 1'b0;
            claim_ack_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            thresh_q    <= thresh_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            ext_irq_q   <= ext_irq_d;
            claim_ack_q <= claim_ack_d;
            claim_id_q  <= claim_id_d;
        end
    end

    // Line 0 request, the unused bit 0 strobes and the winning priority are intentionally not consumed.
    assign sig_unused = irq_src_i[0] ^ claim_vec[0] ^ complete_vec[0] ^ (^best_prio_q);

    assign bus.claim_ack = claim_ack_q;
    assign bus.claim_id  = claim_id_q;
    assign pending_o     = gw_pending;
    assign ext_irq_o     = ext_irq_q;
endmodule

// File: tb/tb_plic_irq_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural PLIC model.
// Latency: n/a.
// Backpressure: n/a.
module tb_plic_irq_arbiter;
    import plic_irq_arbiter_pkg::*;

    localparam int NS = PLIC_NUM_SOURCES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] irq_src;
    logic [NS-1:0] pending;
    logic          ext_irq;

    plic_irq_arbiter_if bus ();

    plic_irq_arbiter dut (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .irq_src_i (irq_src),
        .bus       (bus),
        .pending_o (pending),
        .ext_irq_o (ext_irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: what the spec says is visible after each edge.
    bit m_pend [NS];
    bit m_infl [NS];
    int m_prio [NS];
    bit m_en   [NS];
    int m_thr;
    int m_best;
    bit m_ext;
    bit m_ack;
    int m_cid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = eligible source with the largest (priority, -id) pair, scored as one integer.
    function automatic int winner();
        int best_score;
        int w;
        int score;
        best_score = -1;
        w = 0;
        for (int i = 1; i < NS; i++) begin
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr) begin
                score = m_prio[i] * NS + (NS - 1 - i);
                if (score > best_score) begin
                    best_score = score;
                    w = i;
                end
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0;
            m_infl[i] = 0;
            m_prio[i] = 0;
            m_en[i]   = 0;
        end
        m_thr = 0; m_best = 0; m_ext = 0; m_ack = 0; m_cid = 0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit np [NS];
        bit ni [NS];
        int w;
        int cl;
        bit done;
        if (!rst_n) begin
            model_reset();
            return;
        end
        w  = winner();
        cl = 0;
        if (bus.claim_req) begin
            // A selection that is already claimed (inflight) is stale and yields 0.
            cl    = (m_best != 0 && !m_infl[m_best]) ? m_best : 0;
            m_ack = 1;
            m_cid = cl;
        end else begin
            m_ack = 0;
        end
        np[0] = 0;
        ni[0] = 0;
        for (int i = 1; i < NS; i++) begin
            done  = bus.complete_valid && (int'(bus.complete_id) == i);
            ni[i] = (m_infl[i] && !done) || (cl == i);
            np[i] = (cl == i) ? 1'b0 : (m_pend[i] || (irq_src[i] && !m_infl[i]));
        end
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = np[i];
            m_infl[i] = ni[i];
        end
        m_best = w;
        m_ext  = (w != 0);
        if (bus.cfg_we) begin
            case (int'(bus.cfg_sel))
                0: if (bus.cfg_idx != 0) m_prio[bus.cfg_idx] = int'(bus.cfg_wdata);
                1: if (bus.cfg_idx != 0) m_en[bus.cfg_idx]   = bus.cfg_wdata[0];
                2: m_thr = int'(bus.cfg_wdata);
                default: ;
            endcase
        end
    endtask

    // One clock: model and DUT cross the same edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ext_irq",   {31'd0, ext_irq},       {31'd0, m_ext});
        chk("claim_ack", {31'd0, bus.claim_ack}, {31'd0, m_ack});
        chk("claim_id",  32'(bus.claim_id),      32'(m_cid));
        chk("pending",   pending,                model_pending());
        bus.cfg_we         = 1'b0;
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic cfg_write(input int sel, input int idx, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 2'(sel);
        bus.cfg_idx   = 5'(idx);
        bus.cfg_wdata = 3'(data);
        cycle();
    endtask

    task automatic do_claim(input string tag, input int exp_id);
        bus.claim_req = 1'b1;
        cycle();
        chk({tag, "_ack"}, {31'd0, bus.claim_ack}, 32'd1);
        chk({tag, "_id"},  32'(bus.claim_id),      32'(exp_id));
    endtask

    task automatic do_complete(input int id);
        bus.complete_valid = 1'b1;
        bus.complete_id    = 5'(id);
        cycle();
    endtask

    function automatic int pick_complete_id();
        int q[$];
        for (int i = 1; i < NS; i++) if (m_infl[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) return q[$urandom_range(0, q.size() - 1)];
        return int'($urandom_range(0, NS - 1));
    endfunction

    initial begin
        model_reset();
        rst_n              = 1'b0;
        irq_src            = '0;
        bus.cfg_we         = 1'b0;
        bus.cfg_sel        = '0;
        bus.cfg_idx        = '0;
        bus.cfg_wdata      = '0;
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;

        // Reset state
        idle(2);
        chk("rst_ext",  {31'd0, ext_irq},       32'd0);
        chk("rst_ack",  {31'd0, bus.claim_ack}, 32'd0);
        chk("rst_id",   32'(bus.claim_id),      32'd0);
        chk("rst_pend", pending,                32'd0);
        rst_n = 1'b1;
        idle(1);

        // UART line 4: 2-cycle latency, claim returns 4
        cfg_write(0, PLIC_UART_INTERRUPT, 3);
        cfg_write(1, PLIC_UART_INTERRUPT, 1);
        irq_src = 32'h10;
        cycle();
        chk("uart_ext_1cyc", {31'd0, ext_irq}, 32'd0);
        cycle();
        chk("uart_ext_2cyc", {31'd0, ext_irq}, 32'd1);
        irq_src = '0;
        do_claim("uart", 4);
        chk("uart_pend4", {31'd0, pending[4]}, 32'd0);
        do_complete(4);

        // Equal priorities: lowest ID first; stale back-to-back claim returns 0
        cfg_write(0, 2, 5);
        cfg_write(1, 2, 1);
        cfg_write(0, 3, 5);
        cfg_write(1, 3, 1);
        irq_src = 32'h0C;
        cycle();
        irq_src = '0;
        idle(2);
        do_claim("tie_first", 2);
        idle(1);
        do_claim("tie_second", 3);
        do_complete(2);
        do_complete(3);
        cfg_write(0, 3, 6);
        irq_src = 32'h0C;
        cycle();
        irq_src = '0;
        idle(2);
        do_claim("hiprio", 3);
        do_claim("stale", 0);
        do_claim("after_stale", 2);
        do_complete(3);
        do_complete(2);

        // Threshold gating
        cfg_write(2, 0, 4);
        cfg_write(0, 2, 4);
        irq_src = 32'h04;
        idle(3);
        chk("thr_masked", {31'd0, ext_irq}, 32'd0);
        cfg_write(2, 0, 3);
        chk("thr_1cyc", {31'd0, ext_irq}, 32'd0);
        cycle();
        chk("thr_open", {31'd0, ext_irq}, 32'd1);
        irq_src = '0;
        do_claim("thr_claim", 2);
        do_complete(2);

        // Held source: no re-pend while inflight, bogus complete ignored
        cfg_write(2, 0, 0);
        cfg_write(0, PLIC_GPIO_IN_INTERRUPT, 2);
        cfg_write(1, PLIC_GPIO_IN_INTERRUPT, 1);
        irq_src = 32'h02;
        idle(3);
        do_claim("held", 1);
        idle(3);
        chk("held_no_repend", {31'd0, pending[1]}, 32'd0);
        do_complete(7);
        idle(1);
        chk("bogus_complete", {31'd0, pending[1]}, 32'd0);
        do_complete(1);
        chk("repend_edge", {31'd0, pending[1]}, 32'd0);
        cycle();
        chk("repend", {31'd0, pending[1]}, 32'd1);
        irq_src = '0;
        idle(2);
        do_claim("held2", 1);
        do_complete(1);

        // Empty claim and line 0 writes
        idle(2);
        do_claim("empty", 0);
        chk("empty_pend", pending, 32'd0);
        cfg_write(1, 0, 1);
        cfg_write(0, 0, 7);
        irq_src = 32'h01;
        idle(3);
        chk("line0_ext",  {31'd0, ext_irq}, 32'd0);
        chk("line0_pend", pending,          32'd0);
        irq_src = '0;

        // Reset the cycle after a claim
        irq_src = 32'h10;
        idle(3);
        bus.claim_req = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("rstclaim_ack",  {31'd0, bus.claim_ack}, 32'd0);
        chk("rstclaim_pend", pending,                32'd0);
        chk("rstclaim_ext",  {31'd0, ext_irq},       32'd0);
        rst_n   = 1'b1;
        irq_src = '0;
        idle(2);
        chk("rstclaim_noack", {31'd0, bus.claim_ack}, 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 5) == 0) irq_src = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 2) == 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_sel   = 2'($urandom_range(0, 3));
                bus.cfg_idx   = 5'($urandom_range(0, NS - 1));
                bus.cfg_wdata = (bus.cfg_sel == 2'd2) ? 3'($urandom_range(0, 3))
                                                      : 3'($urandom_range(0, 7));
            end
            bus.claim_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.complete_valid = 1'b1;
                bus.complete_id    = 5'(pick_complete_id());
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
